// File: rtl/add_seq_pkg.sv
// Purpose : shared types and constants for the add_seq serial adder.
// Latency : n/a (package only).
// Backpressure: n/a. Contents: FSM state encoding, lane width, index-width helper.
package add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the lane index counter; a single-lane adder still needs one bit.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/add_seq_if.sv
// Purpose : operand/result handshake bundle for add_seq.
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports   : master = producer/consumer side, slave = the adder block.
interface add_seq_if
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [BYTE_W*NBYTES-1:0] in_a;
  logic [BYTE_W*NBYTES-1:0] in_b;
  logic                     in_ci;
  logic                     out_valid;
  logic                     out_ready;
  logic [BYTE_W*NBYTES-1:0] out_sum;
  logic                     out_co;
  logic                     busy;

  modport master (
    output in_valid, in_a, in_b, in_ci, out_ready,
    input  in_ready, out_valid, out_sum, out_co, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, out_ready,
    output in_ready, out_valid, out_sum, out_co, busy
  );

endinterface

// File: rtl/add.sv
// Purpose : existing 8-bit ripple-carry adder, {co,x} = a + b + ci.
// Latency : combinational.
// Backpressure: none. Ports: a, b (8b), ci (1b) in; x (8b), co (1b) out.
module add (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] x,
  output logic       co
);

  logic c;

  always_comb begin
    x = '0;
    c = ci;
    for (int i = 0; i < 8; i++) begin
      x[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/add_seq.sv
// Purpose : NBYTES-wide serial adder, one byte per cycle LSB first through one 8-bit add.
// Latency : out_valid rises NBYTES edges after the accepting edge; one op per NBYTES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports   : clk, rst_n (async, active-low), io (add_seq_if.slave: operands, result, busy).
module add_seq
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  add_seq_if.slave     io
);

  localparam int IDX_W = idx_width(NBYTES);

  state_t state, state_nxt;

  logic [IDX_W-1:0]                   idx;
  logic                               carry;
  logic [NBYTES-1:0][BYTE_W-1:0]      a_q;
  logic [NBYTES-1:0][BYTE_W-1:0]      b_q;
  logic [NBYTES-1:0][BYTE_W-1:0]      sum_q;
  logic                               co_q;

  logic                               in_ready_c;
  logic                               out_valid_c;
  logic                               busy_c;
  logic                               accept;
  logic                               last;

  logic [BYTE_W-1:0]                  lane_x;
  logic                               lane_co;

  assign last = (idx == IDX_W'(NBYTES - 1));

  add u_add (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .ci (carry),
    .x  (lane_x),
    .co (lane_co)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        accept     = io.in_valid;
        if (io.in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (io.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, carry, index and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= io.in_a;
      b_q   <= io.in_b;
      carry <= io.in_ci;
      sum_q <= '0;
      co_q  <= 1'b0;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_q[idx] <= lane_x;
      carry      <= lane_co;
      if (last) co_q <= lane_co;
      else      idx  <= idx + 1'b1;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_c;
  assign io.busy      = busy_c;
  assign io.out_sum   = sum_q;
  assign io.out_co    = co_q;

endmodule

// File: tb/tb_add_seq.sv
// Purpose : self-checking bench for add_seq at NBYTES=4 and NBYTES=1.
// Latency : n/a.
// Backpressure: exercises out_ready stalls and in_valid held during busy.
module tb_add_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  add_seq_if #(.NBYTES(4)) i4 ();
  add_seq_if #(.NBYTES(1)) i1 ();

  add_seq #(.NBYTES(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(i4));
  add_seq #(.NBYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(i1));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: -1 idle, 0..N-1 edges consumed since accept, N result presented.
  int          m4_ph = -1;
  int          m1_ph = -1;
  logic [31:0] m4_sum = '0;
  logic        m4_co = 1'b0;
  logic [7:0]  m1_sum = '0;
  logic        m1_co = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m4_ph <= -1;
    else if (m4_ph < 0) begin
      if (i4.in_valid) begin
        m4_ph <= 0;
        {m4_co, m4_sum} <= 33'(i4.in_a) + 33'(i4.in_b) + 33'(i4.in_ci);
      end
    end else if (m4_ph < 4) m4_ph <= m4_ph + 1;
    else if (i4.out_ready) m4_ph <= -1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m1_ph <= -1;
    else if (m1_ph < 0) begin
      if (i1.in_valid) begin
        m1_ph <= 0;
        {m1_co, m1_sum} <= 9'(i1.in_a) + 9'(i1.in_b) + 9'(i1.in_ci);
      end
    end else if (m1_ph < 1) m1_ph <= m1_ph + 1;
    else if (i1.out_ready) m1_ph <= -1;
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("m4_in_ready",  64'(i4.in_ready),  64'(m4_ph < 0));
    check("m4_busy",      64'(i4.busy),      64'(m4_ph >= 0));
    check("m4_out_valid", 64'(i4.out_valid), 64'(m4_ph == 4));
    if (m4_ph == 4) begin
      check("m4_out_sum", 64'(i4.out_sum), 64'(m4_sum));
      check("m4_out_co",  64'(i4.out_co),  64'(m4_co));
    end
    check("m1_in_ready",  64'(i1.in_ready),  64'(m1_ph < 0));
    check("m1_busy",      64'(i1.busy),      64'(m1_ph >= 0));
    check("m1_out_valid", 64'(i1.out_valid), 64'(m1_ph == 1));
    if (m1_ph == 1) begin
      check("m1_out_sum", 64'(i1.out_sum), 64'(m1_sum));
      check("m1_out_co",  64'(i1.out_co),  64'(m1_co));
    end
  end

  // ---------------- directed stimulus helpers ----------------
  function automatic logic f_rdy(input int s);
    return (s == 1) ? i1.in_ready : i4.in_ready;
  endfunction
  function automatic logic f_vld(input int s);
    return (s == 1) ? i1.out_valid : i4.out_valid;
  endfunction
  function automatic logic [31:0] f_sum(input int s);
    return (s == 1) ? 32'(i1.out_sum) : i4.out_sum;
  endfunction
  function automatic logic f_co(input int s);
    return (s == 1) ? i1.out_co : i4.out_co;
  endfunction

  task automatic drive(input int s, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic ordy);
    if (s == 1) begin
      i1.in_valid = v; i1.in_a = a[7:0]; i1.in_b = b[7:0]; i1.in_ci = ci; i1.out_ready = ordy;
    end else begin
      i4.in_valid = v; i4.in_a = a; i4.in_b = b; i4.in_ci = ci; i4.out_ready = ordy;
    end
  endtask

  // One operation with literal expectations; hold>0 stalls out_ready and keeps in_valid high.
  task automatic op(input string name, input int s, input logic [31:0] a, input logic [31:0] b,
                    input logic ci, input logic [31:0] xs, input logic xco,
                    input int xlat, input int hold);
    int lat;
    @(negedge clk);
    check({name, "_rdy_before"}, 64'(f_rdy(s)), 64'd1);
    drive(s, 1'b1, a, b, ci, hold == 0);
    @(negedge clk);                         // accepting edge has passed
    if (hold == 0) drive(s, 1'b0, a, b, ci, 1'b1);
    lat = 0;
    while (!f_vld(s) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(xlat));
    for (int h = 0; h < hold; h++) begin
      check({name, "_hold_sum"}, 64'(f_sum(s)), 64'(xs));
      check({name, "_hold_co"},  64'(f_co(s)),  64'(xco));
      check({name, "_hold_rdy"}, 64'(f_rdy(s)), 64'd0);
      @(negedge clk);
    end
    check({name, "_sum"}, 64'(f_sum(s)), 64'(xs));
    check({name, "_co"},  64'(f_co(s)),  64'(xco));
    drive(s, (hold != 0), a, b, ci, 1'b1);
    @(negedge clk);                         // DONE -> IDLE edge has passed
    check({name, "_rdy_after"}, 64'(f_rdy(s)), 64'd1);
    check({name, "_vld_after"}, 64'(f_vld(s)), 64'd0);
    drive(s, 1'b0, a, b, ci, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive(4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(i4.in_ready),  64'd1);
    check("rst_out_valid", 64'(i4.out_valid), 64'd0);
    check("rst_busy",      64'(i4.busy),      64'd0);
    check("rst_out_sum",   64'(i4.out_sum),   64'd0);
    check("rst_out_co",    64'(i4.out_co),    64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    op("zero",   4, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 4, 0);
    op("byte01", 4, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 4, 0);
    op("ripple", 4, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 4, 0);
    op("stall",  4, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 32'hFFFFFFFF, 1'b0, 4, 3);
    op("mixed",  4, 32'h80000000, 32'h80000001, 1'b1, 32'h00000002, 1'b1, 4, 0);

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk);
    drive(4, 1'b1, 32'h01010101, 32'h01010101, 1'b0, 1'b1);
    @(negedge clk);                         // accepted
    drive(4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);                         // first RUN edge done
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(i4.in_ready), 64'd1);
    check("midrst_busy",     64'(i4.busy),     64'd0);
    check("midrst_sum",      64'(i4.out_sum),  64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("postrst_out_valid", 64'(i4.out_valid), 64'd0);
    end
    op("after_rst", 4, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 4, 0);

    op("one_byte", 1, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1, 0);
    op("one_plain", 1, 32'h00000012, 32'h00000034, 1'b1, 32'h00000047, 1'b0, 1, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
- Multi-byte serial adder built around the team's existing 8-bit ripple adder `add` (ports a, b, ci, x, co).
- Accepts two NBYTES-wide operands plus a carry-in over a valid/ready handshake.
- Feeds `add` one byte per cycle, LSB first, chaining the carry through a register, and presents the full sum and final carry on an output valid/ready handshake.
- Sits directly upstream of `add`, which it drives, and consumes `add`'s outputs.

Parameters:
- NBYTES, 4, number of 8-bit lanes per operand; legal range ≥1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept operands.
- in_a  in  8*NBYTES  operand A.
- in_b  in  8*NBYTES  operand B.
- in_ci  in  1  carry-in into byte 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  8*NBYTES  sum.
- out_co  out  1  carry out of the top byte.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- States: IDLE, RUN, DONE. Registered state.
- Reset: all state is cleared.
  - state=IDLE, byte index=0, carry reg=0.
  - Operand regs=0, out_sum=0, out_co=0, out_valid=0, busy=0.
  - in_ready=1, since in_ready = (state==IDLE) and is therefore also 1 while rst_n is low.
- IDLE: on an edge with in_valid&&in_ready:
  - latch in_a and in_b;
  - carry reg←in_ci;
  - clear out_sum;
  - index←0;
  - go to RUN.
- RUN, each edge:
  - drive `add` with a=A[8*idx+:8], b=B[8*idx+:8], ci=carry reg;
  - out_sum[8*idx+:8]←x;
  - carry reg←co;
  - if idx==NBYTES-1, then out_co←co and go to DONE; else idx←idx+1.
  - in_valid is ignored.
- DONE:
  - out_valid=1.
  - out_sum and out_co are held stable until out_ready.
  - On an edge with out_valid&&out_ready, go to IDLE. in_ready rises on the next cycle; there is no same-cycle reaccept.
- Latency: out_valid rises on the NBYTES-th edge after the accepting edge.
- Throughput: one operation per NBYTES+2 cycles when out_ready is held high.
- Arithmetic:
  - Unsigned, modulo 2^(8*NBYTES).
  - {out_co,out_sum} = in_a + in_b + in_ci, exactly.
  - No saturation or overflow flag.
- Index counter width: max(1,$clog2(NBYTES)). NBYTES=1 gives one RUN cycle.
- out_sum bytes not yet computed read 0 during RUN. Only the value at out_valid is specified.
- Reset asserted mid-RUN or mid-DONE:
  - immediate return to reset values;
  - the in-flight operation is discarded;
  - no out_valid pulse follows reset release.
- in_valid asserted in RUN/DONE: no effect, no queuing.
- out_ready asserted outside DONE: no effect.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and lane width constant BYTE_W=8.
- One sub-module instance: the existing `add`, used unmodified, one instance.
- The FSM, counter, carry reg and operand/result regs live in add_seq.

Test Plan:
- NBYTES=4, a=0, b=0, ci=0 → out_sum=0x00000000, out_co=0; out_valid on the 4th edge after acceptance.
- a=0x000000FF, b=0x00000001, ci=0 → out_sum=0x00000100, out_co=0 (carry crosses byte 0→1).
- a=0xFFFFFFFF, b=0, ci=1 → out_sum=0x00000000, out_co=1 (full-width ripple).
- a=0x0F0F0F0F, b=0xF0F0F0F0, ci=0, out_ready held 0 for 3 cycles, in_valid=1 throughout:
  - out_sum=0xFFFFFFFF and out_co=0 stay stable;
  - in_ready=0 and no second accept;
  - after out_ready=1, back to IDLE with in_ready=1 next cycle.
- Reset pulsed on the 2nd RUN cycle:
  - out_valid stays 0 and in_ready=1 after release;
  - next op a=0x12345678, b=0x11111111, ci=1 → out_sum=0x2345678A, out_co=0.
- NBYTES=1, a=0xFF, b=0x01, ci=0 → out_sum=0x00, out_co=1; out_valid on the 1st edge after acceptance.
